// File: rtl/ft232h_debug_pkg.sv
// Shared types and constants for the FT232H-driven virtual-JTAG debug host.
package ft232h_debug_pkg;

    localparam int unsigned DR_WIDTH_DEFAULT = 38;
    localparam int unsigned IR_WIDTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        StIdle,
        StUir,
        StCdr,
        StSdr,
        StUdr,
        StResp
    } state_e;

    // Debug slave virtual-IR encodings
    localparam logic [IR_WIDTH_DEFAULT-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [IR_WIDTH_DEFAULT-1:0] IR_TRACE     = 2'd1;
    localparam logic [IR_WIDTH_DEFAULT-1:0] IR_BREAK     = 2'd2;
    localparam logic [IR_WIDTH_DEFAULT-1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/ft232h_debug_tck_gen.sv
// Test-clock generator: low phase first, one-cycle pulses on the edges that start each phase.
module ft232h_debug_tck_gen #(
    parameter int unsigned TCK_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic fall_en,
    output logic rise_en
);

    localparam int unsigned CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

    logic [CW-1:0] cnt_q;
    logic          tck_q;
    logic          phase_end;

    assign phase_end = run && (cnt_q == CW'(TCK_HALF - 1));
    assign rise_en   = phase_end && !tck_q;
    assign fall_en   = phase_end && tck_q;
    assign tck       = tck_q;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (phase_end) begin
            cnt_q <= '0;
            tck_q <= !tck_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/ft232h_debug_jtag_host.sv
// Host-side virtual-JTAG driver: one command = IR update followed by a full DR scan.
module ft232h_debug_jtag_host
    import ft232h_debug_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int unsigned IR_WIDTH = IR_WIDTH_DEFAULT,
    parameter int unsigned TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    localparam int unsigned CNT_W = $clog2(DR_WIDTH + 1);

    state_e              state_q, state_d;
    logic [DR_WIDTH-1:0] tx_q, rx_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                rsp_valid_q;
    logic                run, tck_fall, tck_rise, accept, rsp_fire;

    assign run       = (state_q == StUir) || (state_q == StCdr) ||
                       (state_q == StSdr) || (state_q == StUdr);
    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid_q && rsp_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rx_q;
    assign vji_ir_in = ir_q;
    assign vji_tdi   = (state_q == StSdr) && tx_q[0];

    ft232h_debug_tck_gen #(
        .TCK_HALF(TCK_HALF)
    ) u_tck_gen (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .tck    (vji_tck),
        .fall_en(tck_fall),
        .rise_en(tck_rise)
    );

    always_comb begin
        state_d = state_q;
        vji_rti = 1'b0;
        vji_uir = 1'b0;
        vji_cdr = 1'b0;
        vji_sdr = 1'b0;
        vji_udr = 1'b0;
        unique case (state_q)
            StIdle: begin
                vji_rti = 1'b1;
                if (cmd_valid) state_d = StUir;
            end
            StUir: begin
                vji_uir = 1'b1;
                if (tck_fall) state_d = StCdr;
            end
            StCdr: begin
                vji_cdr = 1'b1;
                if (tck_fall) state_d = StSdr;
            end
            StSdr: begin
                vji_sdr = 1'b1;
                // Leave on the low-phase start that follows the last rising edge
                if (tck_fall && bit_cnt_q == CNT_W'(DR_WIDTH)) state_d = StUdr;
            end
            StUdr: begin
                vji_udr = 1'b1;
                if (tck_fall) state_d = StResp;
            end
            StResp: begin
                vji_rti = 1'b1;
                if (rsp_fire) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            ir_q        <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q      <= cmd_ir;
                tx_q      <= cmd_dr;
                rx_q      <= '0;
                bit_cnt_q <= '0;
            end
            if (state_q == StSdr && tck_rise) begin
                rx_q      <= {vji_tdo, rx_q[DR_WIDTH-1:1]};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (state_q == StSdr && tck_fall) begin
                tx_q <= {1'b0, tx_q[DR_WIDTH-1:1]};
            end
            // Response is published one cycle after entering RESP
            if (rsp_fire) begin
                rsp_valid_q <= 1'b0;
            end else if (state_q == StResp) begin
                rsp_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ft232h_debug_jtag_host.sv
// Directed bench: table of scans against a model target shift register, plus corner sequences.
module tb_ft232h_debug_jtag_host;

    localparam int DW   = 38;
    localparam int IW   = 2;
    localparam int TH   = 2;
    localparam int LAT  = 1 + (DW + 3) * 2 * TH;
    localparam int SDW  = 4;
    localparam int SLAT = 1 + (SDW + 3) * 2 * 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [IW-1:0] cmd_ir, vji_ir_in;
    logic [DW-1:0] cmd_dr, rsp_data;
    logic          vji_tck, vji_tdi, vji_tdo, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;

    logic           cmd_valid_s, cmd_ready_s, rsp_valid_s, rsp_ready_s;
    logic [IW-1:0]  cmd_ir_s, vji_ir_in_s;
    logic [SDW-1:0] cmd_dr_s, rsp_data_s;
    logic           vji_tck_s, vji_tdi_s, vji_rti_s, vji_uir_s, vji_cdr_s, vji_sdr_s, vji_udr_s;
    logic           tdo_s_q;

    ft232h_debug_jtag_host dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
        .vji_udr(vji_udr)
    );

    ft232h_debug_jtag_host #(
        .DR_WIDTH(SDW), .IR_WIDTH(IW), .TCK_HALF(1)
    ) dut_s (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s), .cmd_ir(cmd_ir_s),
        .cmd_dr(cmd_dr_s), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready_s),
        .rsp_data(rsp_data_s), .vji_tck(vji_tck_s), .vji_tdi(vji_tdi_s), .vji_tdo(tdo_s_q),
        .vji_ir_in(vji_ir_in_s), .vji_rti(vji_rti_s), .vji_uir(vji_uir_s),
        .vji_cdr(vji_cdr_s), .vji_sdr(vji_sdr_s), .vji_udr(vji_udr_s)
    );

    // Model target: capture preload on CDR, shift on tck rise during SDR.
    logic [DW-1:0] tsr, preload;
    assign vji_tdo = tsr[0];
    always @(posedge vji_tck) begin
        if (vji_sdr)      tsr <= {vji_tdi, tsr[DW-1:1]};
        else if (vji_cdr) tsr <= preload;
    end

    always @(posedge clk) tdo_s_q <= vji_tdi_s;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [IW-1:0] ir;
        logic [DW-1:0] dr;
        logic [DW-1:0] pre;
        logic [DW-1:0] exp_rsp;
        logic [DW-1:0] exp_tgt;
    } vec_t;

    vec_t vecs[4];

    task automatic do_scan(input vec_t v, input string tag);
        int lat, n_uir, n_cdr, n_sdr, n_udr, n_rise, proto, irbad, seqbad, stage, s, sum, w;
        logic tck_prev;
        preload = v.pre;
        w = 0;
        while (!cmd_ready && w < 1000) begin
            @(posedge clk); #1; w++;
        end
        check($sformatf("%s ready", tag), cmd_ready, 1);
        cmd_ir = v.ir; cmd_dr = v.dr; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_ir = ~v.ir; cmd_dr = ~v.dr;
        lat = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rise = 0;
        proto = 0; irbad = 0; seqbad = 0; stage = 0; tck_prev = 1'b0;
        while (!rsp_valid && lat < 2 * LAT) begin
            n_uir += int'(vji_uir); n_cdr += int'(vji_cdr);
            n_sdr += int'(vji_sdr); n_udr += int'(vji_udr);
            sum = int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr);
            if (sum > 1 || vji_rti != (sum == 0) || cmd_ready) proto++;
            s = vji_uir ? 1 : vji_cdr ? 2 : vji_sdr ? 3 : vji_udr ? 4 : 5;
            if (s < stage) seqbad++;
            stage = s;
            if (vji_uir && vji_ir_in !== v.ir) irbad++;
            if (vji_tck && !tck_prev) n_rise++;
            tck_prev = vji_tck;
            @(posedge clk); #1; lat++;
        end
        check($sformatf("%s latency", tag), lat, LAT);
        check($sformatf("%s uir cycles", tag), n_uir, 2 * TH);
        check($sformatf("%s cdr cycles", tag), n_cdr, 2 * TH);
        check($sformatf("%s sdr cycles", tag), n_sdr, DW * 2 * TH);
        check($sformatf("%s udr cycles", tag), n_udr, 2 * TH);
        check($sformatf("%s tck rises", tag), n_rise, DW + 3);
        check($sformatf("%s exclusion", tag), proto, 0);
        check($sformatf("%s strobe order", tag), seqbad, 0);
        check($sformatf("%s ir_in", tag), irbad, 0);
        check($sformatf("%s rsp_data", tag), rsp_data, v.exp_rsp);
        check($sformatf("%s target rx", tag), tsr, v.exp_tgt);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check($sformatf("%s rsp_valid drop", tag), rsp_valid, 0);
        check($sformatf("%s cmd_ready back", tag), cmd_ready, 1);
    endtask

    initial begin
        int bad, rises, n, lat;
        logic tck_prev;
        vec_t b2b, fresh;

        reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0;
        cmd_valid_s = 1'b0; cmd_ir_s = '0; cmd_dr_s = '0; rsp_ready_s = 1'b0;
        preload = '0;

        vecs[0] = '{ir: 2'b01, dr: 38'h2_0000_0001, pre: 38'h3F_0F0F_0F0F,
                    exp_rsp: 38'h3F_0F0F_0F0F, exp_tgt: 38'h2_0000_0001};
        vecs[1] = '{ir: 2'b10, dr: 38'h00_0000_0000, pre: 38'h15_5555_5555,
                    exp_rsp: 38'h15_5555_5555, exp_tgt: 38'h00_0000_0000};
        vecs[2] = '{ir: 2'b11, dr: 38'h3F_FFFF_FFFF, pre: 38'h00_0000_0000,
                    exp_rsp: 38'h00_0000_0000, exp_tgt: 38'h3F_FFFF_FFFF};
        vecs[3] = '{ir: 2'b00, dr: 38'h2A_DEAD_BEEF, pre: 38'h01_2345_6789,
                    exp_rsp: 38'h01_2345_6789, exp_tgt: 38'h2A_DEAD_BEEF};
        b2b     = '{ir: 2'b10, dr: 38'h0A_5A5A_A5A5, pre: 38'h35_C3C3_3C3C,
                    exp_rsp: 38'h35_C3C3_3C3C, exp_tgt: 38'h0A_5A5A_A5A5};
        fresh   = '{ir: 2'b01, dr: 38'h00_0000_0000, pre: 38'h2B_1234_5678,
                    exp_rsp: 38'h2B_1234_5678, exp_tgt: 38'h00_0000_0000};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (vji_tck || !vji_rti || !cmd_ready || rsp_valid ||
                vji_uir || vji_cdr || vji_sdr || vji_udr) bad++;
        end
        check("idle stable", bad, 0);
        check("reset tck", vji_tck, 0);
        check("reset tdi", vji_tdi, 0);
        check("reset ir_in", vji_ir_in, 0);
        check("reset rti", vji_rti, 1);
        check("reset rsp_data", rsp_data, 0);
        check("reset small ready", cmd_ready_s, 1);

        for (int i = 0; i < 3; i++) begin
            do_scan(vecs[i], $sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end

        // Back-pressure on the response with a second command already offered
        do_scan(vecs[3], "vec3");
        cmd_ir = b2b.ir; cmd_dr = b2b.dr; cmd_valid = 1'b1;
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (cmd_ready || !rsp_valid || rsp_data !== vecs[3].exp_rsp || vji_tck ||
                vji_uir || vji_cdr || vji_sdr || vji_udr) bad++;
        end
        check("hold stable", bad, 0);
        handshake("hold");
        do_scan(b2b, "b2b");
        handshake("b2b");

        // Reset at the tenth tck rise inside SDR
        cmd_ir = 2'b11; cmd_dr = 38'h1F_FFFF_0000; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rises = 0; n = 0; tck_prev = 1'b0;
        while (rises < 10 && n < 500) begin
            @(posedge clk); #1; n++;
            if (vji_tck && !tck_prev && vji_sdr) rises++;
            tck_prev = vji_tck;
        end
        check("midscan reached", rises, 10);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midscan tck", vji_tck, 0);
        check("midscan tdi", vji_tdi, 0);
        check("midscan ir_in", vji_ir_in, 0);
        check("midscan rti", vji_rti, 1);
        check("midscan strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr}, 0);
        check("midscan rsp_valid", rsp_valid, 0);
        check("midscan rsp_data", rsp_data, 0);
        check("midscan cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid || vji_tck) bad++;
        end
        check("midscan no partial rsp", bad, 0);
        do_scan(fresh, "fresh");
        handshake("fresh");

        // Small variant: tdo is tdi delayed by one clk, so capture is the command shifted up
        cmd_ir_s = 2'b10; cmd_dr_s = 4'b1010; cmd_valid_s = 1'b1;
        @(posedge clk); #1;
        cmd_valid_s = 1'b0; cmd_dr_s = 4'b0101;
        lat = 0;
        while (!rsp_valid_s && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("small latency", lat, SLAT);
        check("small rsp_data", rsp_data_s, 4'b0100);
        check("small ir_in", vji_ir_in_s, 2'b10);
        rsp_ready_s = 1'b1;
        @(posedge clk); #1;
        rsp_ready_s = 1'b0;
        check("small rsp_valid drop", rsp_valid_s, 0);
        check("small cmd_ready back", cmd_ready_s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ft232h_debug_jtag_host.md
Name: ft232h_debug_jtag_host

Overview:
- Host-side driver for the CPU debug slave's virtual-JTAG interface. It generates the tck/tdi/ir_in/virtual-state signals that the sld_virtual_jtag_basic primitive normally produces, and captures tdo.
- One command is one IR write (UIR) followed by a full DR scan (CDR, SDR×DR_WIDTH, UDR).
- Sits between an FT232H command bridge and the debug slave's vji_* nets, replacing the JTAG hard path for bench and board-level debug access.

Parameters:
- DR_WIDTH, 38, scan length in bits; matches the debug slave shift register.
- IR_WIDTH, 2, width of the virtual IR.
- TCK_HALF, 2, clk cycles per tck half-period; legal range ≥1.

Ports:
- clk  in  1  system clock; tck is derived from it.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_dr  in  DR_WIDTH  DR bits to shift in, LSB first.
- rsp_valid  out  1  captured DR available.
- rsp_ready  in  1  consumer accepts rsp_data.
- rsp_data  out  DR_WIDTH  bits captured from tdo; first captured bit in bit 0.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to target.
- vji_tdo  in  1  serial data from target.
- vji_ir_in  out  IR_WIDTH  current virtual IR.
- vji_rti  out  1  run-test-idle indication.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual state strobes.

Behaviour:
- Reset values:
  - vji_tck=0, vji_tdi=0, vji_ir_in=0, vji_rti=1.
  - vji_uir, vji_cdr, vji_sdr, vji_udr = 0.
  - rsp_valid=0, rsp_data=0, cmd_ready=1, state=IDLE.
- tck timing:
  - One tck period = 2×TCK_HALF clk cycles: low phase first, high phase second.
  - All vji outputs change only on the clk edge that starts a low phase.
  - vji_tdo is sampled on the clk edge that starts a high phase.
- States: IDLE → UIR → CDR → SDR → UDR → RESP → IDLE.
  - UIR, CDR and UDR each last exactly one tck period.
  - SDR lasts exactly DR_WIDTH tck periods.
- IDLE:
  - vji_tck held 0, vji_rti=1, cmd_ready=1.
  - Accept happens when cmd_valid && cmd_ready. The same edge latches cmd_ir into vji_ir_in, loads cmd_dr into the tx shifter, clears rx, sets rti=0 and uir=1.
- UIR: uir=1 only; vji_ir_in stays stable until the next accept.
- CDR: cdr=1; no tdo capture.
- SDR:
  - sdr=1 and vji_tdi = tx[0].
  - At each rising tck: rx = {tdo, rx[DR_WIDTH-1:1]}.
  - At each following low-phase start: tx shifts right, filling 0.
  - A bit counter of width clog2(DR_WIDTH+1) counts DR_WIDTH rising edges, then the block moves to UDR.
- UDR: udr=1 for one period; tdi=0.
- RESP:
  - tck held 0, rti=1, rsp_data=rx, rsp_valid=1, cmd_ready=0.
  - On rsp_valid && rsp_ready → IDLE; cmd_ready rises the next cycle.
  - While rsp_ready=0, rsp_valid and rsp_data are held stable indefinitely.
- Latency: rsp_valid rises exactly 1+(DR_WIDTH+3)×2×TCK_HALF clk cycles after the accept edge. Defaults give 165.
- Mutual exclusion: at most one of uir/cdr/sdr/udr is high in any cycle. rti is high only in IDLE and RESP.
- Ignored inputs: cmd_valid is ignored outside IDLE; cmd_* changes after accept have no effect.
- Reset mid-scan: the next clk edge forces all reset values regardless of state or tck phase. No partial response is produced.
- Back-to-back commands: cmd_valid held high in RESP is accepted the cycle after the response handshake. There is no overlap.

Decomposition:
- Shared package ft232h_debug_pkg:
  - state enum (IDLE, UIR, CDR, SDR, UDR, RESP);
  - DR_WIDTH/IR_WIDTH defaults;
  - debug-slave IR encodings (0 = ocimem, 1 = trace/break readback, 2 = break, 3 = tracectrl).
- One sub-module is natural: ft232h_debug_tck_gen, which produces vji_tck plus one-cycle fall_en/rise_en pulses from TCK_HALF and a run enable. The FSM and shifters stay in the top.

Test Plan:
- Reset then idle 20 cycles → tck=0, rti=1, cmd_ready=1, rsp_valid=0, no strobes.
- Scan with cmd_ir=2'b01, cmd_dr=38'h2_0000_0001; bench target shift register preloaded at cdr with 38'h3F_0F0F_0F0F and shifting on tck rise → rsp_data=38'h3F_0F0F_0F0F, target received 38'h2_0000_0001, rsp_valid at cycle 165, ir_in=01 during uir.
- Check strobe count and ordering per command: uir, cdr, udr one tck period each; sdr 38 periods; tdi stable across each rising edge.
- rsp_ready held 0 for 50 cycles, second cmd_valid asserted → cmd_ready=0, rsp_data unchanged, no tck activity; after handshake the second command starts with no lost or duplicated bits.
- reset asserted at tck rise #10 of SDR → next cycle all reset values; a following fresh command with cmd_dr=0 returns the correct capture.
- TCK_HALF=1, DR_WIDTH=4 variant: cmd_dr=4'b1010, tdo looped to delayed tdi → latency 1+7×2=15 cycles; rx matches the loopback pattern.
